// File: rtl/sha256_result_checker_pkg.sv
// Shared hash widths, checker FSM encoding and the 32-bit word reversal helper.
// Pure declarations: no latency, no backpressure.
package sha256_result_checker_pkg;

    localparam int HASH_W = 256;
    localparam int WORD_W = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    function automatic logic [HASH_W-1:0] word_reverse(input logic [HASH_W-1:0] d);
        logic [HASH_W-1:0] r;
        r = '0;
        for (int i = 0; i < HASH_W / WORD_W; i++) begin
            r[i*WORD_W +: WORD_W] = d[(HASH_W/WORD_W-1-i)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous first-word-fall-through FIFO; head is valid combinationally whenever !empty.
// Latency: a write in cycle N is readable from cycle N+1. Backpressure: writes dropped when
// full unless a read happens in the same cycle, which frees the slot.
module fifo_sync #(
    parameter int WIDTH      = 256,
    parameter int DEPTH      = 256,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_rd;
    logic                do_wr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && resetn && !clear) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/sha256_result_checker.sv
// In-order hash scoreboard: queued expected hashes compared against DUT results.
// Latency: counters, flags and FSM reflect an accept one cycle later. Backpressure:
// res_ready drops only in HALT; pushes while full are dropped and flagged.
module sha256_result_checker
    import sha256_result_checker_pkg::*;
#(
    parameter int DATA_WIDTH      = HASH_W,
    parameter int FIFO_DEPTH      = 256,
    parameter int FIFO_DEPTH_LOG2 = 8,
    parameter int CNT_W           = 32,
    parameter int REVERSE_WORDS   = 0,
    parameter int STOP_ON_ERR     = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  exp_valid,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  exp_full,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_ready,
    output logic [CNT_W-1:0]      match_cnt,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  err_sticky,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic                  halted
);

    localparam int N_WORDS = DATA_WIDTH / WORD_W;

    logic [DATA_WIDTH-1:0] res_cmp;
    logic [DATA_WIDTH-1:0] head;
    logic                  q_empty;
    logic                  q_full;
    logic                  acc;
    logic                  pop;
    logic                  mis_now;
    logic [0:0]            state;
    logic [CNT_W-1:0]      res_idx;

    for (genvar i = 0; i < N_WORDS; i++) begin : g_rev
        assign res_cmp[i*WORD_W +: WORD_W] = (REVERSE_WORDS != 0) ?
            res_data[(N_WORDS-1-i)*WORD_W +: WORD_W] : res_data[i*WORD_W +: WORD_W];
    end

    assign res_ready  = (state == ST_RUN);
    assign halted     = (state == ST_HALT);
    assign acc        = res_valid & res_ready;
    assign pop        = acc & ~q_empty;
    // An accept against an empty queue is a mismatch regardless of data.
    assign mis_now    = acc & (q_empty | (head != res_cmp));
    assign exp_full   = q_full;
    assign err_sticky = err_overflow | err_underflow | (mismatch_cnt != '0);

    fifo_sync #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_exp_q (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (clear),
        .wr_en   (exp_valid),
        .wr_data (exp_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            state         <= ST_RUN;
            res_idx       <= '0;
            match_cnt     <= '0;
            mismatch_cnt  <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            first_err_idx <= '0;
            first_err_got <= '0;
        end else begin
            if (exp_valid && q_full && !pop) err_overflow <= 1'b1;
            if (acc) begin
                res_idx <= res_idx + CNT_W'(1);
                if (q_empty) err_underflow <= 1'b1;
                if (mis_now) begin
                    if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    // mismatch_cnt never returns to zero, so this captures only once.
                    if (mismatch_cnt == '0) begin
                        first_err_idx <= res_idx;
                        first_err_got <= res_cmp;
                    end
                    if (STOP_ON_ERR != 0) state <= ST_HALT;
                end else if (match_cnt != '1) begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
